param_pic: RTL and testbench

PARAM_PIC -- requirements
Module: param_pic

---
 rtl/param_pic.sv | 209 ++++++++++++++++++++
 tb/tb_param_pic.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_pic.sv
// ---------------------------------------------------------------------------
// param_pic : parameterised programmable interrupt controller
//
// Collects up to N_IRQ request lines into IRR (edge or level captured).
// Requests are filtered by IMR and resolved by fixed or rotating priority
// with full nesting against ISR. Two inta pulses acknowledge a request:
// the first latches the winner, and the second presents the vector.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   irq_in         request lines, synchronous to clk
//   wr_en/rd_en    register write / read strobes
//   addr, wdata    register select (0 CFG/IRR, 1 IMR, 2 CMD/ISR, 3 status)
//   rdata          registered read data
//   inta           acknowledge strobe from the CPU
//   int_out        interrupt request to the CPU
//   vector_out     vector {base, id} of the acknowledged interrupt
//   vector_valid   one-cycle qualifier for vector_out
//   ack_state      debug view of the acknowledge FSM (0 IDLE, 1 ACK1, 2 VEC)
//
// Handshake: every strobe (wr_en, rd_en, inta) is a single-cycle pulse that
// is sampled on the rising edge. There is no back-pressure. vector_valid is
// high for exactly the cycle after the second inta.
// ---------------------------------------------------------------------------
module param_pic #(
   parameter int N_IRQ = 8,
   parameter int VEC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [1:0]       addr,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata,
   input  logic             inta,
   output logic             int_out,
   output logic [VEC_W-1:0] vector_out,
   output logic             vector_valid,
   output logic [1:0]       ack_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK1 = 2'd1, S_VEC = 2'd2} state_t;

   state_t           state;
   logic             ltim, aeoi, rotate;
   logic [4:0]       base;
   logic [N_IRQ-1:0] irr, isr, imr, prev;
   logic [2:0]       lp;
   logic [2:0]       ack_id;
   logic             ack_spur;

   logic [2:0]       rank [N_IRQ];
   logic             isr_any, any_elig;
   logic [2:0]       isr_top_id, isr_top_rank, win_id, win_rank;
   logic [N_IRQ-1:0] isr_set, isr_clr, irr_clr;
   logic [2:0]       lp_next;
   logic [7:0]       vec8;

   assign ack_state = state;
   assign vec8      = {base, ack_id};

   // Rank 0 is the highest priority. In rotate mode, level lp+1 gets rank 0.
   always_comb begin
      for (int i = 0; i < N_IRQ; i++) begin
         if (!rotate)
            rank[i] = 3'(i);
         else if (i > int'(lp))
            rank[i] = 3'(i - int'(lp) - 1);
         else
            rank[i] = 3'(i + N_IRQ - 1 - int'(lp));
      end
   end

   // Find the highest in-service level. An unmasked request is eligible only
   // when it outranks that level. The winner is the best eligible request.
   always_comb begin
      isr_any      = 1'b0;
      isr_top_id   = '0;
      isr_top_rank = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (isr[i] && (!isr_any || rank[i] < isr_top_rank)) begin
            isr_any      = 1'b1;
            isr_top_id   = 3'(i);
            isr_top_rank = rank[i];
         end
      end
      any_elig = 1'b0;
      win_id   = '0;
      win_rank = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (irr[i] && !imr[i] && (!isr_any || rank[i] < isr_top_rank) &&
             (!any_elig || rank[i] < win_rank)) begin
            any_elig = 1'b1;
            win_id   = 3'(i);
            win_rank = rank[i];
         end
      end
   end

   // Set/clear masks for this cycle. The acknowledge and a CMD write can land
   // together. A CMD rotation update overrides an AEOI rotation update.
   always_comb begin
      isr_set = '0;
      isr_clr = '0;
      irr_clr = '0;
      lp_next = lp;
      if (state == S_IDLE && inta && any_elig) begin
         isr_set[win_id] = 1'b1;
         if (!ltim) irr_clr[win_id] = 1'b1;
      end
      if (state == S_ACK1 && inta && aeoi && !ack_spur) begin
         isr_clr[ack_id] = 1'b1;
         if (rotate) lp_next = ack_id;
      end
      if (wr_en && addr == 2'd2) begin
         case (wdata[7:6])
            2'b01: if (isr_any) begin
               isr_clr[isr_top_id] = 1'b1;
               if (rotate) lp_next = isr_top_id;
            end
            2'b10: if (int'(wdata[2:0]) < N_IRQ) begin
               isr_clr[wdata[2:0]] = 1'b1;
               if (rotate) lp_next = wdata[2:0];
            end
            2'b11: if (int'(wdata[2:0]) < N_IRQ) lp_next = wdata[2:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         ltim         <= 1'b0;
         aeoi         <= 1'b0;
         rotate       <= 1'b0;
         base         <= '0;
         irr          <= '0;
         isr          <= '0;
         imr          <= '0;
         prev         <= '0;
         lp           <= 3'(N_IRQ - 1);
         ack_id       <= '0;
         ack_spur     <= 1'b0;
         rdata        <= '0;
         int_out      <= 1'b0;
         vector_out   <= '0;
         vector_valid <= 1'b0;
      end else begin
         prev         <= irq_in;
         vector_valid <= 1'b0;
         lp           <= lp_next;
         // The set is applied after the clear, so the set wins on a shared bit.
         isr          <= (isr & ~isr_clr) | isr_set;
         if (ltim)
            irr <= irq_in;
         else
            irr <= (irr & ~irr_clr) | (irq_in & ~prev);

         if (wr_en && addr == 2'd0) begin
            ltim   <= wdata[0];
            aeoi   <= wdata[1];
            rotate <= wdata[2];
            base   <= wdata[7:3];
         end
         if (wr_en && addr == 2'd1)
            imr <= wdata[N_IRQ-1:0];

         if (rd_en) begin
            case (addr)
               2'd0:    rdata <= 8'(irr);
               2'd1:    rdata <= 8'(imr);
               2'd2:    rdata <= 8'(isr);
               default: rdata <= {int_out, 4'b0000, win_id};
            endcase
         end

         case (state)
            S_IDLE: begin
               int_out <= inta ? 1'b0 : any_elig;
               if (inta) begin
                  ack_id   <= any_elig ? win_id : 3'(N_IRQ - 1);
                  ack_spur <= !any_elig;
                  state    <= S_ACK1;
               end
            end
            S_ACK1: begin
               int_out <= 1'b0;
               if (inta) begin
                  vector_out   <= VEC_W'(vec8);
                  vector_valid <= 1'b1;
                  state        <= S_VEC;
               end
            end
            S_VEC: begin
               int_out <= any_elig;
               state   <= S_IDLE;
            end
            default: begin
               int_out <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_pic.sv
// ---------------------------------------------------------------------------
// tb_param_pic : directed bench for param_pic (N_IRQ = 8, VEC_W = 8).
// Inputs change on the falling edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_param_pic;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] irq_in = '0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [1:0] addr = '0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic       inta = 1'b0;
   logic       int_out;
   logic [7:0] vector_out;
   logic       vector_valid;
   logic [1:0] ack_state;

   int checks = 0;
   int errors = 0;

   param_pic #(.N_IRQ(8), .VEC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .wr_en(wr_en), .rd_en(rd_en),
      .addr(addr), .wdata(wdata), .rdata(rdata), .inta(inta), .int_out(int_out),
      .vector_out(vector_out), .vector_valid(vector_valid), .ack_state(ack_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; irq_in = '0; wr_en = 1'b0; rd_en = 1'b0; inta = 1'b0;
      wait_n(2);
      rst_n = 1'b1;
   endtask

   task automatic do_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      rd_en = 1'b1; addr = a;
      @(negedge clk);
      rd_en = 1'b0;
      d = rdata;
   endtask

   task automatic do_ack();
      @(negedge clk);
      inta = 1'b1;
      @(negedge clk);
      inta = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out: got %b want 0", int_out); end
      checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL reset_vvalid: got %b want 0", vector_valid); end
      checks++; if (vector_out !== 8'h00) begin errors++; $display("FAIL reset_vector: got %h want 00", vector_out); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
      checks++; if (ack_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", ack_state); end
   endtask

   task automatic test_edge_ack();
      logic [7:0] d;
      do_wr(2'd0, 8'h40);
      @(negedge clk); irq_in = 8'h08;
      wait_n(1);
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL edge_int_early: got %b want 0", int_out); end
      wait_n(1);
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL edge_int_rise: got %b want 1", int_out); end
      do_ack();
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL edge_int_drop: got %b want 0", int_out); end
      do_ack();
      checks++; if (vector_valid !== 1'b1 || vector_out !== 8'h43) begin errors++; $display("FAIL edge_vector: got v=%b %h want v=1 43", vector_valid, vector_out); end
      wait_n(1);
      checks++; if (vector_valid !== 1'b0 || vector_out !== 8'h43) begin errors++; $display("FAIL edge_vector_hold: got v=%b %h want v=0 43", vector_valid, vector_out); end
      do_rd(2'd2, d);
      checks++; if (d !== 8'h08) begin errors++; $display("FAIL edge_isr: got %h want 08", d); end
      do_rd(2'd0, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_irr_cleared: got %h want 00", d); end
   endtask

   task automatic test_nesting();
      logic [7:0] d;
      @(negedge clk); irq_in = 8'h28;
      wait_n(2);
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL nest_irq5_blocked: got %b want 0", int_out); end
      @(negedge clk); irq_in = 8'h2A;
      wait_n(2);
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL nest_irq1_int: got %b want 1", int_out); end
      do_ack(); do_ack();
      checks++; if (vector_out !== 8'h41) begin errors++; $display("FAIL nest_vec1: got %h want 41", vector_out); end
      do_rd(2'd2, d);
      checks++; if (d !== 8'h0A) begin errors++; $display("FAIL nest_isr_0a: got %h want 0a", d); end
      do_wr(2'd2, 8'h40);
      do_rd(2'd2, d);
      checks++; if (d !== 8'h08) begin errors++; $display("FAIL nest_eoi1: got %h want 08", d); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL nest_irq5_still_blocked: got %b want 0", int_out); end
      do_wr(2'd2, 8'h40);
      wait_n(1);
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL nest_irq5_int: got %b want 1", int_out); end
      do_ack(); do_ack();
      checks++; if (vector_out !== 8'h45) begin errors++; $display("FAIL nest_vec5: got %h want 45", vector_out); end
   endtask

   task automatic test_rotate();
      logic [7:0] d;
      apply_reset();
      do_wr(2'd0, 8'h44);
      @(negedge clk); irq_in = 8'h05;
      wait_n(2);
      do_rd(2'd3, d);
      checks++; if (d !== 8'h80) begin errors++; $display("FAIL rot_status0: got %h want 80", d); end
      do_ack(); do_ack();
      checks++; if (vector_out !== 8'h40) begin errors++; $display("FAIL rot_vec0: got %h want 40", vector_out); end
      do_wr(2'd2, 8'h40);
      do_ack(); do_ack();
      checks++; if (vector_out !== 8'h42) begin errors++; $display("FAIL rot_vec2: got %h want 42", vector_out); end
      @(negedge clk); irq_in = 8'h04;
      @(negedge clk); irq_in = 8'h05;
      wait_n(2);
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL rot_irq0_low: got %b want 0", int_out); end
      do_rd(2'd0, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL rot_irr0: got %h want 01", d); end
      do_wr(2'd2, 8'h82);
      do_wr(2'd2, 8'hC0);
      @(negedge clk); irq_in = 8'h85;
      wait_n(2);
      do_rd(2'd3, d);
      checks++; if (d !== 8'h87) begin errors++; $display("FAIL rot_irq7_over_0: got %h want 87", d); end
   endtask

   task automatic test_aeoi_level();
      logic [7:0] d;
      apply_reset();
      do_wr(2'd0, 8'h43);
      @(negedge clk); irq_in = 8'h40;
      wait_n(2);
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL aeoi_int: got %b want 1", int_out); end
      do_ack(); do_ack();
      checks++; if (vector_valid !== 1'b1 || vector_out !== 8'h46) begin errors++; $display("FAIL aeoi_vec: got v=%b %h want v=1 46", vector_valid, vector_out); end
      do_rd(2'd2, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL aeoi_isr: got %h want 00", d); end
      do_rd(2'd0, d);
      checks++; if (d !== 8'h40) begin errors++; $display("FAIL aeoi_irr: got %h want 40", d); end
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL aeoi_reassert: got %b want 1", int_out); end
   endtask

   task automatic test_spurious();
      logic [7:0] d;
      apply_reset();
      do_wr(2'd1, 8'hFF);
      @(negedge clk); irq_in = 8'hFF;
      wait_n(2);
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL spur_int: got %b want 0", int_out); end
      do_ack();
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL spur_int_ack: got %b want 0", int_out); end
      do_ack();
      checks++; if (vector_valid !== 1'b1 || vector_out !== 8'h07) begin errors++; $display("FAIL spur_vec: got v=%b %h want v=1 07", vector_valid, vector_out); end
      do_rd(2'd2, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL spur_isr: got %h want 00", d); end
      do_rd(2'd0, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL spur_irr: got %h want ff", d); end
      do_rd(2'd1, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL spur_imr: got %h want ff", d); end
   endtask

   task automatic test_reset_mid_ack();
      logic [7:0] d;
      apply_reset();
      do_wr(2'd0, 8'h40);
      @(negedge clk); irq_in = 8'h08;
      wait_n(2);
      do_rd(2'd0, d);
      checks++; if (d !== 8'h08) begin errors++; $display("FAIL mid_irr_pre: got %h want 08", d); end
      do_ack();
      checks++; if (ack_state !== 2'd1) begin errors++; $display("FAIL mid_in_ack1: got %0d want 1", ack_state); end
      @(negedge clk); rst_n = 1'b0; irq_in = '0;
      @(negedge clk); rst_n = 1'b1;
      checks++; if (int_out !== 1'b0 || vector_valid !== 1'b0 || vector_out !== 8'h00 || rdata !== 8'h00) begin
         errors++; $display("FAIL mid_outputs: got int=%b v=%b vec=%h rd=%h want all 0", int_out, vector_valid, vector_out, rdata);
      end
      checks++; if (ack_state !== 2'd0) begin errors++; $display("FAIL mid_state: got %0d want 0", ack_state); end
      do_rd(2'd2, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_isr: got %h want 00", d); end
      do_rd(2'd0, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_irr: got %h want 00", d); end
      do_ack();
      checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL mid_first_pulse: got v=%b want 0", vector_valid); end
      wait_n(1);
      checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL mid_first_pulse_late: got v=%b want 0", vector_valid); end
      do_ack();
      checks++; if (vector_valid !== 1'b1 || vector_out !== 8'h07) begin errors++; $display("FAIL mid_second_pulse: got v=%b %h want v=1 07", vector_valid, vector_out); end
   endtask

   // sequence and final report
   initial begin
      test_reset();
      test_edge_ack();
      test_nesting();
      test_rotate();
      test_aeoi_level();
      test_spurious();
      test_reset_mid_ack();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
